lcd_text_buffer: RTL



---
 rtl/lcd_text_pkg.sv | 16 +
 rtl/lcd_text_ram.sv | 33 +++
 rtl/lcd_text_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lcd_text_pkg.sv
// Shared constants and state type for the character-LCD text buffer.
// Control codes are only decoded when LCD_TEXT_BUF_CTRL_EN is defined.
package lcd_text_pkg;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_SP = 8'h20;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

endpackage

// File: rtl/lcd_text_ram.sv
// Simple dual-port character store: synchronous write, registered read.
// Read-before-write on a same-address collision.
module lcd_text_ram #(
    parameter int DEPTH = 32,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_text_buffer.sv
// Character frame buffer with cursor, clear sequence and read port.
// Define LCD_TEXT_BUF_CTRL_EN to decode CR/LF/BS/FF and drop other controls.
module lcd_text_buffer
    import lcd_text_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 2,
    parameter int DW   = 8,
    parameter logic [DW-1:0] FILL = DW'(8'h20),
    localparam int DEPTH = ROWS * COLS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_index,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] cursor,
    output logic          wrap_pulse,
    output logic          busy
);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, cursor_nxt;
    logic          xfer, clear_done, printable, wrap_set;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    assign xfer       = wr_valid && wr_ready;
    assign clear_done = (ptr == AW'(DEPTH - 1));

`ifdef LCD_TEXT_BUF_CTRL_EN
    logic [AW-1:0] col;
    assign printable = (wr_data >= DW'(CHR_SP));
    assign col       = AW'(int'(cursor) % COLS);
`else
    assign printable = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (clear_done) state_nxt = RUN;
            RUN: begin
`ifdef LCD_TEXT_BUF_CTRL_EN
                if (xfer && wr_data == DW'(CHR_FF)) state_nxt = CLEAR;
`endif
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        wr_ready = (state == RUN);
        busy     = (state == CLEAR);
    end

    // Single write port shared by the fill sweep, printing and backspace.
    always_comb begin
        we         = 1'b0;
        waddr      = cursor;
        wdata      = wr_data;
        cursor_nxt = cursor;
        wrap_set   = 1'b0;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = ptr;
            wdata = FILL;
            if (clear_done) cursor_nxt = '0;
        end else if (xfer) begin
            if (printable) begin
                we = 1'b1;
                if (cursor == AW'(DEPTH - 1)) begin
                    cursor_nxt = '0;
                    wrap_set   = 1'b1;
                end else begin
                    cursor_nxt = cursor + AW'(1);
                end
            end
`ifdef LCD_TEXT_BUF_CTRL_EN
            else begin
                case (wr_data)
                    DW'(CHR_CR): cursor_nxt = cursor - col;
                    DW'(CHR_LF): begin
                        if (cursor >= AW'(DEPTH - COLS)) begin
                            cursor_nxt = cursor - AW'(DEPTH - COLS);
                            wrap_set   = 1'b1;
                        end else begin
                            cursor_nxt = cursor + AW'(COLS);
                        end
                    end
                    DW'(CHR_BS): begin
                        if (cursor != '0) begin
                            cursor_nxt = cursor - AW'(1);
                            we         = 1'b1;
                            waddr      = cursor - AW'(1);
                            wdata      = FILL;
                        end
                    end
                    default: ;
                endcase
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            cursor     <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            ptr        <= (state == CLEAR && !clear_done) ? ptr + AW'(1) : '0;
            cursor     <= cursor_nxt;
            wrap_pulse <= wrap_set;
        end
    end

    lcd_text_ram #(
        .DEPTH(DEPTH),
        .DW   (DW),
        .AW   (AW)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(rd_index),
        .rdata(rd_data)
    );

endmodule
